// File: rtl/tdm_mem_pkg.sv
// Shared constants for the TDM memory controller: FSM encodings, wait-counter
// width and the byte-to-word address offset.
package tdm_mem_pkg;

    localparam logic [1:0] MEM_IDLE   = 2'd0;
    localparam logic [1:0] MEM_WAIT   = 2'd1;
    localparam logic [1:0] MEM_ACCESS = 2'd2;

    localparam int CNT_W    = 4;
    localparam int WORD_OFS = 2;

endpackage

// File: rtl/tdm_mem_sram.sv
// Synchronous single-port word array; kept behind this thin wrapper so a vendor
// RAM macro can replace it without touching the controller.
module tdm_mem_sram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array and its read register have no reset; clearing a RAM would
    // prevent mapping onto block memory, and contents must survive a reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/tdm_mem_ctrl.sv
// Wait-state memory controller behind the TDM arbiter. Define
// TDM_MEM_BOUNDS_CHECK_EN to flag out-of-range or misaligned accesses on memErr.
module tdm_mem_ctrl
    import tdm_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic              memWr,
    input  logic              memReq,
    input  logic [DATA_W-1:0] memDataIn,
    output logic              memBusyOut,
    output logic [DATA_W-1:0] memDataOut,
    output logic              memErr,
    output logic              reqDrop
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wr_q;
    logic                  bad_q;
    logic [DATA_W-1:0]     data_q;
    logic                  req_bad;

    logic                  sram_en;
    logic [DATA_W-1:0]     sram_rdata;

`ifdef TDM_MEM_BOUNDS_CHECK_EN
    assign req_bad = (memAddr[ADDR_W-1:DEPTH_LOG2+WORD_OFS] != '0) ||
                     (memAddr[WORD_OFS-1:0] != '0);
`else
    logic unused_addr_bits;
    assign req_bad          = 1'b0;
    assign unused_addr_bits = ^{memAddr[ADDR_W-1:DEPTH_LOG2+WORD_OFS], memAddr[WORD_OFS-1:0]};
`endif

    // Reads are launched in the last wait cycle so the array output is ready in
    // ACCESS; writes commit on the edge that leaves ACCESS, so a reset before
    // that edge drops them.
    assign sram_en = !bad_q &&
                     (((state == MEM_WAIT) && (cnt == '0) && !wr_q) ||
                      ((state == MEM_ACCESS) && wr_q));

    tdm_mem_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (wr_q),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (sram_rdata)
    );

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= MEM_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            bad_q      <= 1'b0;
            data_q     <= '0;
            memBusyOut <= 1'b0;
            memDataOut <= '0;
            memErr     <= 1'b0;
            reqDrop    <= 1'b0;
        end else begin
            reqDrop <= memReq && (state != MEM_IDLE);
            case (state)
                MEM_IDLE: begin
                    if (memReq) begin
                        idx_q      <= memAddr[DEPTH_LOG2+WORD_OFS-1:WORD_OFS];
                        wr_q       <= memWr;
                        bad_q      <= req_bad;
                        data_q     <= memDataIn;
                        memBusyOut <= 1'b1;
                        memErr     <= 1'b0;
                        cnt        <= WAIT_INIT;
                        state      <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (cnt == '0) begin
                        state <= MEM_ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MEM_ACCESS: begin
                    if (!wr_q) begin
                        memDataOut <= bad_q ? '0 : sram_rdata;
                    end
                    if (bad_q) begin
                        memErr <= 1'b1;
                    end
                    memBusyOut <= 1'b0;
                    state      <= MEM_IDLE;
                end
                default: begin
                    memBusyOut <= 1'b0;
                    state      <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mem_ctrl.sv
// Self-checking bench: one controller with two wait states, one with none,
// checked by directed tables, corner sequences and a random word-level model.
module tb_tdm_mem_ctrl;

    localparam int W0    = 2;
    localparam int W1    = 0;
    localparam int WORDS = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_s   [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        busy_s  [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];
    logic        drop_s  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain word arrays plus the last value read per instance.
    logic [31:0] model_mem [2][WORDS];
    bit          model_vld [2][WORDS];
    logic [31:0] last_rd   [2];
    bit          last_vld  [2];

    tdm_mem_ctrl #(.WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(rst_n), .memAddr(addr_s[0]), .memWr(wr_s[0]),
        .memReq(req_s[0]), .memDataIn(wdata_s[0]), .memBusyOut(busy_s[0]),
        .memDataOut(rdata_s[0]), .memErr(err_s[0]), .reqDrop(drop_s[0])
    );

    tdm_mem_ctrl #(.WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(rst_n), .memAddr(addr_s[1]), .memWr(wr_s[1]),
        .memReq(req_s[1]), .memDataIn(wdata_s[1]), .memBusyOut(busy_s[1]),
        .memDataOut(rdata_s[1]), .memErr(err_s[1]), .reqDrop(drop_s[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef TDM_MEM_BOUNDS_CHECK_EN
        return (a >= 32'h1000) || (a % 4 != 0);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_rd[d]  = '0;
            last_vld[d] = 1'b1;
        end
    endtask

    // Expected result of one access, computed from the word-addressing rules.
    task automatic model_op(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] exp_rd, output bit chk_rd, output logic exp_err);
        int  word;
        bit  bad;
        word    = int'((a / 4) % WORDS);
        bad     = addr_bad(a);
        exp_err = bad;
        if (w) begin
            if (!bad) begin
                model_mem[d][word] = wd;
                model_vld[d][word] = 1'b1;
            end
        end else if (bad) begin
            last_rd[d]  = '0;
            last_vld[d] = 1'b1;
        end else begin
            last_rd[d]  = model_mem[d][word];
            last_vld[d] = model_vld[d][word];
        end
        exp_rd = last_rd[d];
        chk_rd = last_vld[d];
    endtask

    // Pulse one request and follow busy until it falls, bounded by a cycle budget.
    task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          output int bc, output logic [31:0] rd, output logic e, output int drops);
        @(negedge clk);
        req_s[d]   = 1'b1;
        wr_s[d]    = w;
        addr_s[d]  = a;
        wdata_s[d] = wd;
        @(negedge clk);
        req_s[d] = 1'b0;
        bc       = 0;
        drops    = 0;
        while (busy_s[d] && bc < 64) begin
            bc++;
            if (drop_s[d]) drops++;
            @(negedge clk);
        end
        if (drop_s[d]) drops++;
        rd = rdata_s[d];
        e  = err_s[d];
    endtask

    task automatic do_op(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit chk_rd, input logic exp_err,
                         input string tag);
        int          bc;
        int          drops;
        logic [31:0] rd;
        logic        e;
        access(d, w, a, wd, bc, rd, e, drops);
        check({tag, " busy_cycles"}, 32'(bc), (d == 0) ? 32'(W0 + 2) : 32'(W1 + 2));
        check({tag, " reqDrop"}, 32'(drops), 32'd0);
        check({tag, " memErr"}, {31'd0, e}, {31'd0, exp_err});
        if (chk_rd) check({tag, " memDataOut"}, rd, exp_rd);
    endtask

    task automatic model_and_check(input int d, input logic w, input logic [31:0] a,
                                   input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        bit          chk;
        logic        exp_err;
        model_op(d, w, a, wd, exp_rd, chk, exp_err);
        do_op(d, w, a, wd, exp_rd, chk, exp_err, tag);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] m_rd;
        bit          m_chk;
        logic        m_err;
        logic [9:0]  busy_v;
        logic [9:0]  drop_v;

        for (int d = 0; d < 2; d++) begin
            req_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
            for (int i = 0; i < WORDS; i++) model_vld[d][i] = 1'b0;
        end
        model_reset();

        // Asynchronous reset, observed before the first clock edge.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset%0d busy", d), {31'd0, busy_s[d]}, 32'd0);
            check($sformatf("reset%0d data", d), rdata_s[d], 32'd0);
            check($sformatf("reset%0d err", d), {31'd0, err_s[d]}, 32'd0);
            check($sformatf("reset%0d drop", d), {31'd0, drop_s[d]}, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table on the two-wait-state instance.
        vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0,  32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 32'h0,  32'h0,         32'hCAFE_F00D, 1'b0};
`ifdef TDM_MEM_BOUNDS_CHECK_EN
        vecs[4] = '{1'b1, 32'h1000, 32'h55AA_55AA, 32'hCAFE_F00D, 1'b1};
        vecs[5] = '{1'b0, 32'h0,    32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[6] = '{1'b0, 32'h3,    32'h0,         32'h0000_0000, 1'b1};
`else
        vecs[4] = '{1'b1, 32'h1000, 32'h55AA_55AA, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b0, 32'h0,    32'h0,         32'h55AA_55AA, 1'b0};
        vecs[6] = '{1'b0, 32'h3,    32'h0,         32'h55AA_55AA, 1'b0};
`endif
        vecs[7] = '{1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0};
        for (int i = 0; i < 8; i++) begin
            model_op(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, m_rd, m_chk, m_err);
            do_op(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b1,
                  vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Zero-wait instance, arbiter-style I-read then D-write then read-back.
        model_op(1, 1'b0, 32'h0, 32'h0, m_rd, m_chk, m_err);
        do_op(1, 1'b0, 32'h0, 32'h0, m_rd, m_chk, 1'b0, "w0 iread");
        model_op(1, 1'b1, 32'h4, 32'h1234_5678, m_rd, m_chk, m_err);
        do_op(1, 1'b1, 32'h4, 32'h1234_5678, m_rd, m_chk, 1'b0, "w0 dwrite");
        model_op(1, 1'b0, 32'h4, 32'h0, m_rd, m_chk, m_err);
        do_op(1, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b1, 1'b0, "w0 readback");

        // Request held for three cycles: one access, two dropped cycles.
        model_and_check(0, 1'b1, 32'h8, 32'h0BAD_CAFE, "hold prewrite");
        @(negedge clk);
        req_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = 32'h8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_v[i] = busy_s[0];
            drop_v[i] = drop_s[0];
            if (i == 2) req_s[0] = 1'b0;
        end
        check("hold busy pattern", {22'd0, busy_v}, 32'h0000_000F);
        check("hold drop pattern", {22'd0, drop_v}, 32'h0000_0006);
        check("hold read data", rdata_s[0], 32'h0BAD_CAFE);
        model_op(0, 1'b0, 32'h8, 32'h0, m_rd, m_chk, m_err);

        // Reset during the wait phase of a write must not commit it.
        model_and_check(0, 1'b1, 32'h20, 32'h1111_2222, "abort prewrite");
        model_and_check(0, 1'b0, 32'h20, 32'h0, "abort preread");
        @(negedge clk);
        req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'hA5A5_A5A5;
        @(negedge clk);
        req_s[0] = 1'b0;
        check("abort busy before reset", {31'd0, busy_s[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy_s[0]}, 32'd0);
        check("abort data", rdata_s[0], 32'd0);
        check("abort err", {31'd0, err_s[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_and_check(0, 1'b0, 32'h20, 32'h0, "abort readback");

        // Randomized traffic on both instances against the model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++)
                model_and_check(d, 1'b1, 32'(i * 4), $urandom, $sformatf("fill%0d_%0d", d, i));
            for (int i = 0; i < 40; i++) begin
                logic        w;
                logic [31:0] a;
                w = 1'($urandom_range(0, 1));
                a = 32'($urandom_range(0, 15)) << 2;
                if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 12);
                if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
                model_and_check(d, w, a, $urandom, $sformatf("rand%0d_%0d a=%h", d, i, a));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
